// File: rtl/bank_pingpong_distributor.sv
`default_nettype none
// ============================================================================
// Module   : bank_pingpong_distributor
// Purpose  : Writes parallel channel beats into per-channel bank RAMs using
//            two ping-pong block buffers, with backpressure when both are full.
// Revision : 1.0 - initial release
// ============================================================================
module bank_pingpong_distributor #(
    parameter  int CHANNEL_NUMBER    = 3,
    parameter  int CHANNEL_BANDWIDTH = 8,
    parameter  int BLOCK_DEPTH       = 12,
    localparam int ADDR_BITS         = $clog2(BLOCK_DEPTH)
) (
    input  logic                                             I_clk_in,
    input  logic                                             I_rst_in,
    input  logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] I_data_in,
    input  logic                                             I_valid_in,
    input  logic                                             I_sof_in,
    output logic                                             O_ready_out,
    input  logic                                             I_release_in,
    output logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] O_data_out,
    output logic [CHANNEL_NUMBER-1:0][ADDR_BITS:0]           O_address_out,
    output logic [CHANNEL_NUMBER-1:0]                        O_we_out,
    output logic                                             O_block_done,
    output logic                                             O_block_buf,
    output logic [1:0]                                       O_full_out,
    output logic                                             O_sync_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(BLOCK_DEPTH - 1);

    logic [1:0]                                       r_state_q, w_state_d;
    logic                                             r_fill_q,  w_fill_d;
    logic                                             r_rd_q,    w_rd_d;
    logic [1:0]                                       r_full_q,  w_full_d;
    logic [ADDR_BITS-1:0]                             r_cnt_q,   w_cnt_d;
    logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] r_data_q;
    logic [ADDR_BITS:0]                               r_addr_q;
    logic                                             r_we_q;
    logic                                             r_done_q;
    logic                                             r_buf_q;
    logic                                             r_sync_q;

    logic                 w_accept;
    logic                 w_write;
    logic                 w_last;
    logic                 w_release;
    logic                 w_sync_err;
    logic [ADDR_BITS-1:0] w_wr_addr;

    always_ff @(posedge I_clk_in) begin
        if (I_rst_in) begin
            r_state_q <= ST_IDLE;
            r_fill_q  <= 1'b0;
            r_rd_q    <= 1'b0;
            r_full_q  <= 2'b00;
            r_cnt_q   <= '0;
            r_data_q  <= '0;
            r_addr_q  <= '0;
            r_we_q    <= 1'b0;
            r_done_q  <= 1'b0;
            r_buf_q   <= 1'b0;
            r_sync_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_fill_q  <= w_fill_d;
            r_rd_q    <= w_rd_d;
            r_full_q  <= w_full_d;
            r_cnt_q   <= w_cnt_d;
            r_we_q    <= w_write;
            r_done_q  <= w_last;
            r_sync_q  <= w_sync_err;
            if (w_write) begin
                r_data_q <= I_data_in;
                r_addr_q <= {r_fill_q, w_wr_addr};
            end
            if (w_last) begin
                r_buf_q <= r_fill_q;
            end
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_fill_d   = r_fill_q;
        w_rd_d     = r_rd_q;
        w_full_d   = r_full_q;
        w_cnt_d    = r_cnt_q;
        w_accept   = I_valid_in && O_ready_out;
        w_write    = w_accept && ((r_state_q == ST_FILL) || I_sof_in);
        w_wr_addr  = I_sof_in ? '0 : r_cnt_q;
        w_sync_err = w_accept && (r_state_q == ST_FILL) && I_sof_in;
        w_last     = w_write && (w_wr_addr == LAST_ADDR);
        w_release  = I_release_in && r_full_q[r_rd_q];

        if (w_release) begin
            w_full_d[r_rd_q] = 1'b0;
            w_rd_d           = ~r_rd_q;
        end

        if (w_write) begin
            w_cnt_d   = w_wr_addr + 1'b1;
            w_state_d = ST_FILL;
        end

        // Release is folded into w_full_d first, so a same-cycle release of the
        // buffer we switch to avoids a needless WAIT.
        if (w_last) begin
            w_cnt_d            = '0;
            w_full_d[r_fill_q] = 1'b1;
            w_fill_d           = ~r_fill_q;
            w_state_d          = w_full_d[~r_fill_q] ? ST_WAIT : ST_IDLE;
        end

        if (r_state_q == ST_WAIT) begin
            w_state_d = w_full_d[r_fill_q] ? ST_WAIT : ST_IDLE;
        end
    end

    always_comb begin
        O_ready_out = !I_rst_in && (r_state_q != ST_WAIT);
    end

    genvar c;
    generate
        for (c = 0; c < CHANNEL_NUMBER; c++) begin : g_lane
            assign O_address_out[c] = r_addr_q;
            assign O_we_out[c]      = r_we_q;
        end
    endgenerate

    assign O_data_out   = r_data_q;
    assign O_block_done = r_done_q;
    assign O_block_buf  = r_buf_q;
    assign O_full_out   = r_full_q;
    assign O_sync_err   = r_sync_q;

endmodule
`default_nettype wire

// File: tb/tb_bank_pingpong_distributor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_pingpong_distributor
// Purpose  : Directed self-checking bench for bank_pingpong_distributor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_pingpong_distributor;

    logic              clk;
    logic              rst;
    logic [2:0][7:0]   data_in;
    logic              valid;
    logic              sof;
    logic              ready;
    logic              release_p;
    logic [2:0][7:0]   data_out;
    logic [2:0][4:0]   addr_out;
    logic [2:0]        we_out;
    logic              done;
    logic              done_buf;
    logic [1:0]        full;
    logic              sync_err;

    int n_checks = 0;
    int n_errors = 0;

    bank_pingpong_distributor dut (
        .I_clk_in      (clk),
        .I_rst_in      (rst),
        .I_data_in     (data_in),
        .I_valid_in    (valid),
        .I_sof_in      (sof),
        .O_ready_out   (ready),
        .I_release_in  (release_p),
        .O_data_out    (data_out),
        .O_address_out (addr_out),
        .O_we_out      (we_out),
        .O_block_done  (done),
        .O_block_buf   (done_buf),
        .O_full_out    (full),
        .O_sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pat(input int i);
        logic [7:0] a, b, d;
        a = 8'(8'hFF + i);
        b = 8'(8'h55 + i);
        d = 8'(i);
        return {a, b, d};
    endfunction

    function automatic logic [14:0] ad(input logic b, input int c);
        logic [4:0] a;
        a = {b, 4'(c)};
        return {a, a, a};
    endfunction

    // One clock with the given inputs; outputs sampled 1ns after the edge.
    task automatic step(input logic v, input logic s, input logic r, input int i);
        valid     = v;
        sof       = s;
        release_p = r;
        data_in   = pat(i);
        @(posedge clk);
        #1;
        release_p = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sof = 1'b0; release_p = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",    32'(we_out),   32'h0);
        check("rst_full",  32'(full),     32'h0);
        check("rst_ready", 32'(ready),    32'h0);
        check("rst_addr",  32'(addr_out), 32'h0);
        check("rst_data",  32'(data_out), 32'h0);
        check("rst_done",  32'(done),     32'h0);
        rst = 1'b0;
        #1;
        check("ready_idle", 32'(ready), 32'h1);

        // Block 1 into buffer 0
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i == 0, 1'b0, i);
            check("b1_we",   32'(we_out),   32'h7);
            check("b1_addr", 32'(addr_out), 32'(ad(1'b0, i)));
            check("b1_data", 32'(data_out), 32'(pat(i)));
            check("b1_done", 32'(done),     32'(i == 11));
        end
        check("b1_buf",   32'(done_buf), 32'h0);
        check("b1_full",  32'(full),     32'h1);
        check("b1_ready", 32'(ready),    32'h1);

        // Block 2 into buffer 1, no release
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i == 0, 1'b0, i + 32);
            check("b2_we",   32'(we_out),   32'h7);
            check("b2_addr", 32'(addr_out), 32'(ad(1'b1, i)));
        end
        check("b2_done",  32'(done),     32'h1);
        check("b2_buf",   32'(done_buf), 32'h1);
        check("b2_full",  32'(full),     32'h3);
        check("b2_ready", 32'(ready),    32'h0);

        step(1'b1, 1'b1, 1'b0, 99);
        check("wait_we",   32'(we_out),   32'h0);
        check("wait_addr", 32'(addr_out), 32'(ad(1'b1, 11)));
        check("wait_data", 32'(data_out), 32'(pat(43)));

        step(1'b0, 1'b0, 1'b1, 0);
        check("rel_full",  32'(full),  32'h2);
        check("rel_ready", 32'(ready), 32'h1);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 70 + i);
            check("drop_we", 32'(we_out), 32'h0);
        end

        // Block 3 into buffer 0 with a restart at beat 5; last beat meets a release
        for (int i = 0; i < 17; i++) begin
            step(1'b1, (i == 0) || (i == 5), i == 16, i + 100);
            check("b3_we",   32'(we_out),   32'h7);
            check("b3_addr", 32'(addr_out), 32'(ad(1'b0, (i < 5) ? i : i - 5)));
            check("b3_sync", 32'(sync_err), 32'(i == 5));
            check("b3_done", 32'(done),     32'(i == 16));
        end
        check("b3_buf",   32'(done_buf), 32'h0);
        check("b3_full",  32'(full),     32'h1);
        check("b3_ready", 32'(ready),    32'h1);

        // Partial block into buffer 1, then reset at beat 6
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i == 0, 1'b0, i + 150);
            check("b4_addr", 32'(addr_out), 32'(ad(1'b1, i)));
        end
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 200);
        check("mrst_we",    32'(we_out),   32'h0);
        check("mrst_full",  32'(full),     32'h0);
        check("mrst_addr",  32'(addr_out), 32'h0);
        check("mrst_data",  32'(data_out), 32'h0);
        check("mrst_ready", 32'(ready),    32'h0);
        rst = 1'b0;

        step(1'b0, 1'b0, 1'b1, 0);
        check("idle_rel_full", 32'(full),   32'h0);
        check("idle_rel_we",   32'(we_out), 32'h0);

        for (int i = 0; i < 12; i++) begin
            step(1'b1, i == 0, 1'b0, i + 210);
            check("b5_addr", 32'(addr_out), 32'(ad(1'b0, i)));
            check("b5_data", 32'(data_out), 32'(pat(i + 210)));
        end
        check("b5_done", 32'(done),     32'h1);
        check("b5_buf",  32'(done_buf), 32'h0);
        check("b5_full", 32'(full),     32'h1);

        step(1'b0, 1'b0, 1'b0, 0);
        check("end_we",   32'(we_out), 32'h0);
        check("end_done", 32'(done),   32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
